// File: rtl/dm_wt_cache_if.sv
// CPU-side and memory-side bus of the direct-mapped write-through cache.
// "master" is the surrounding system (CPU plus memory); "slave" is the cache.
interface dm_wt_cache_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_ready;
  logic              flush;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, flush, mem_rdata, mem_ack,
    input  cpu_rdata, cpu_ready, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, flush, mem_rdata, mem_ack,
    output cpu_rdata, cpu_ready, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dm_wt_cache.sv
// Direct-mapped, write-through, no-write-allocate data cache with flush.
// Optional hit/miss counters are enabled by defining DM_CACHE_STATS_EN.
module dm_wt_cache #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 16,
  parameter int INDEX_W  = 4,
  parameter int OFFSET_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  dm_wt_cache_if.slave      bus
`ifdef DM_CACHE_STATS_EN
  ,
  output logic [15:0]       hit_cnt,
  output logic [15:0]       miss_cnt
`endif
);

  localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W;
  localparam int LINES = 1 << INDEX_W;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FILL  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;

  logic [1:0]        state;
  logic [DATA_W-1:0] data_q [LINES];
  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [LINES-1:0]  valid_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              mem_req_q;
  logic              mem_we_q;

  logic [INDEX_W-1:0] cpu_idx;
  logic [TAG_W-1:0]   cpu_tag;
  logic [INDEX_W-1:0] fill_idx;
  logic [TAG_W-1:0]   fill_tag;
  logic               hit;
  logic               idle_go;
  logic               rd_hit;
  logic               rd_miss;
  logic               wr_go;
  logic               fill_done;
  logic               write_done;
  logic               unused_offset;

  assign cpu_idx  = bus.cpu_addr[OFFSET_W +: INDEX_W];
  assign cpu_tag  = bus.cpu_addr[ADDR_W-1 -: TAG_W];
  assign fill_idx = addr_q[OFFSET_W +: INDEX_W];
  assign fill_tag = addr_q[ADDR_W-1 -: TAG_W];
  assign unused_offset = ^bus.cpu_addr[OFFSET_W-1:0];

  assign hit        = valid_q[cpu_idx] && (tag_q[cpu_idx] == cpu_tag);
  // Flush wins over a simultaneous request; the request is served next cycle.
  assign idle_go    = (state == S_IDLE) && bus.cpu_req && !bus.flush;
  assign rd_hit     = idle_go && !bus.cpu_we && hit;
  assign rd_miss    = idle_go && !bus.cpu_we && !hit;
  assign wr_go      = idle_go && bus.cpu_we;
  assign fill_done  = (state == S_FILL)  && bus.mem_ack;
  assign write_done = (state == S_WRITE) && bus.mem_ack;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      mem_req_q <= 1'b0;
      mem_we_q  <= 1'b0;
      valid_q   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.flush) begin
            valid_q <= '0;
          end else if (rd_miss) begin
            state     <= S_FILL;
            mem_req_q <= 1'b1;
            mem_we_q  <= 1'b0;
          end else if (wr_go) begin
            state     <= S_WRITE;
            mem_req_q <= 1'b1;
            mem_we_q  <= 1'b1;
          end
        end
        S_FILL: begin
          if (bus.mem_ack) begin
            valid_q[fill_idx] <= 1'b1;
            state             <= S_IDLE;
            mem_req_q         <= 1'b0;
          end
        end
        S_WRITE: begin
          if (bus.mem_ack) begin
            state     <= S_IDLE;
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
          end
        end
        default: begin
          state     <= S_IDLE;
          mem_req_q <= 1'b0;
          mem_we_q  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (idle_go) begin
      addr_q  <= bus.cpu_addr;
      wdata_q <= bus.cpu_wdata;
    end
  end

  // NOTE: the line array has no reset (valid bits alone make stale contents
  // harmless); rst_n only gates writes so an abandoned fill never lands.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (fill_done) begin
        data_q[fill_idx] <= bus.mem_rdata;
        tag_q[fill_idx]  <= fill_tag;
      end else if (wr_go && hit) begin
        data_q[cpu_idx] <= bus.cpu_wdata;
      end
    end
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    bus.cpu_ready = 1'b0;
    bus.cpu_rdata = data_q[cpu_idx];
    if (rd_hit || fill_done || write_done) bus.cpu_ready = 1'b1;
    if (state == S_FILL) bus.cpu_rdata = bus.mem_rdata;
  end

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;

`ifdef DM_CACHE_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      if (rd_hit && hit_cnt != 16'hFFFF) hit_cnt <= hit_cnt + 16'd1;
      if (rd_miss && miss_cnt != 16'hFFFF) miss_cnt <= miss_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dm_wt_cache.sv
// Self-checking bench for dm_wt_cache: directed scenarios then random traffic
// checked against a word-level memory model plus a "which word each line holds" map.
module tb_dm_wt_cache;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  dm_wt_cache_if #(.DATA_W(16), .ADDR_W(16)) bus ();

`ifdef DM_CACHE_STATS_EN
  logic [15:0] hit_cnt;
  logic [15:0] miss_cnt;
`endif

  dm_wt_cache #(
    .DATA_W(16), .ADDR_W(16), .INDEX_W(4), .OFFSET_W(2)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus)
`ifdef DM_CACHE_STATS_EN
    ,
    .hit_cnt  (hit_cnt),
    .miss_cnt (miss_cnt)
`endif
  );

  // Reference: backing memory by word address; line_word[i] = word held by line i, -1 if none.
  logic [15:0] ref_mem [0:16383];
  int          line_word [16];
  int          n_cmp = 0;
  int          n_err = 0;
  int          exp_hits = 0;
  int          exp_miss = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_invalidate();
    for (int i = 0; i < 16; i++) line_word[i] = -1;
  endtask

  // Starts and ends one time unit after a rising edge.
  task automatic access(input bit we, input logic [15:0] addr, input logic [15:0] wd,
                        input int delay);
    int w;
    int idx;
    bit hit;
    w   = int'(addr[15:2]);
    idx = int'(addr[5:2]);
    hit = (line_word[idx] == w);
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = we;
    bus.cpu_addr  = addr;
    bus.cpu_wdata = wd;
    @(negedge clk);
    if (!we && hit) begin
      check("hit_ready", 32'(bus.cpu_ready), 32'd1);
      check("hit_rdata", 32'(bus.cpu_rdata), 32'(ref_mem[w]));
      check("hit_no_mem_req", 32'(bus.mem_req), 32'd0);
      exp_hits++;
      step();
      bus.cpu_req = 1'b0;
      return;
    end
    check("stall_ready", 32'(bus.cpu_ready), 32'd0);
    check("mem_req_late", 32'(bus.mem_req), 32'd0);
    if (!we) exp_miss++;
    step();
    for (int c = 1; c <= delay; c++) begin
      bus.mem_ack   = (c == delay);
      bus.mem_rdata = (c == delay && !we) ? ref_mem[w] : 16'($urandom);
      @(negedge clk);
      check("mem_req", 32'(bus.mem_req), 32'd1);
      check("mem_we", 32'(bus.mem_we), 32'(we));
      check("mem_addr", 32'(bus.mem_addr), 32'(addr));
      if (we) check("mem_wdata", 32'(bus.mem_wdata), 32'(wd));
      check("wait_ready", 32'(bus.cpu_ready), 32'(c == delay));
      if (c == delay && !we) check("fill_rdata", 32'(bus.cpu_rdata), 32'(ref_mem[w]));
      step();
    end
    bus.mem_ack = 1'b0;
    bus.cpu_req = 1'b0;
    if (we) ref_mem[w] = wd;
    else    line_word[idx] = w;
    @(negedge clk);
    check("mem_req_drop", 32'(bus.mem_req), 32'd0);
    step();
  endtask

  task automatic check_counters(input string tag);
`ifdef DM_CACHE_STATS_EN
    check({tag, "_hit_cnt"}, 32'(hit_cnt), 32'(exp_hits));
    check({tag, "_miss_cnt"}, 32'(miss_cnt), 32'(exp_miss));
`else
    if (tag.len() == 0) $display("empty counter tag");
`endif
  endtask

  logic [9:0] tag_pool [4];

  initial begin
    tag_pool[0] = 10'h000; tag_pool[1] = 10'h001;
    tag_pool[2] = 10'h002; tag_pool[3] = 10'h3FF;
    for (int i = 0; i < 16384; i++) ref_mem[i] = 16'($urandom);
    ref_mem[16'h0010 >> 2] = 16'hBEEF;
    model_invalidate();

    rst_n = 1'b0;
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.flush = 1'b0; bus.mem_ack = 1'b0; bus.mem_rdata = '0;
    step(); step();
    rst_n = 1'b1;
    step();
    @(negedge clk);
    check("rst_ready", 32'(bus.cpu_ready), 32'd0);
    check("rst_mem_req", 32'(bus.mem_req), 32'd0);
    check("rst_mem_we", 32'(bus.mem_we), 32'd0);
    check_counters("rst");
    step();

    // Fill, re-hit, conflict miss, write hit, write miss without allocate.
    access(1'b0, 16'h0010, 16'h0000, 3);
    access(1'b0, 16'h0010, 16'h0000, 1);
    access(1'b0, 16'h0050, 16'h0000, 2);
    access(1'b0, 16'h0010, 16'h0000, 2);
    access(1'b1, 16'h0010, 16'h1234, 2);
    access(1'b0, 16'h0010, 16'h0000, 1);
    check("write_hit_value", 32'(ref_mem[16'h0010 >> 2]), 32'h1234);
    access(1'b1, 16'h0080, 16'hAAAA, 1);
    access(1'b0, 16'h0080, 16'h0000, 2);

    // Flush with a simultaneous read of a cached address.
    bus.flush = 1'b1; bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0010;
    @(negedge clk);
    check("flush_ready", 32'(bus.cpu_ready), 32'd0);
    step();
    bus.flush = 1'b0;
    model_invalidate();
    access(1'b0, 16'h0010, 16'h0000, 2);
    check_counters("directed");

    // Reset in the middle of a fill.
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0050;
    step();
    @(negedge clk);
    check("abort_mem_req_up", 32'(bus.mem_req), 32'd1);
    step();
    rst_n = 1'b0; bus.cpu_req = 1'b0;
    step();
    @(negedge clk);
    check("abort_mem_req_low", 32'(bus.mem_req), 32'd0);
    check("abort_ready", 32'(bus.cpu_ready), 32'd0);
    step();
    rst_n = 1'b1;
    model_invalidate();
    exp_hits = 0; exp_miss = 0;
    step();
    access(1'b0, 16'h0050, 16'h0000, 2);
    access(1'b0, 16'h0050, 16'h0000, 1);
    access(1'b0, 16'h0050, 16'h0000, 1);
    access(1'b0, 16'h0054, 16'h0000, 3);
    access(1'b0, 16'h0054, 16'h0000, 1);
    check_counters("after_reset");

    // Random traffic over a small tag pool so hits, conflicts and flushes all occur.
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 24) == 0) begin
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        model_invalidate();
      end else begin
        logic [15:0] a;
        a = {tag_pool[$urandom_range(0, 3)], 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
        access($urandom_range(0, 3) == 0, a, 16'($urandom), int'($urandom_range(1, 4)));
      end
    end
    check_counters("random");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dm_wt_cache.md
# dm_wt_cache

Parametrised direct-mapped, write-through, no-write-allocate cache placed between the CPU data port and the backing data memory. It replaces the tagless 16x16 cache RAM with tagged lines, valid bits, a miss-handling FSM with a request/ack handshake to memory, a whole-cache flush, and optional hit/miss counters. Read hits complete combinationally in the request cycle. Misses and all writes stall the CPU through `cpu_ready` until memory acknowledges.

## Interface
- `DATA_W`, 16, data word width.
- `ADDR_W`, 16, CPU/memory address width.
- `INDEX_W`, 4, index bits (2**INDEX_W lines, one word per line).
- `OFFSET_W`, 2, low address bits ignored. With defaults, index = `addr[5:2]`.
- `clk`  in  1  clock, all state updates on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `cpu_req`  in  1  CPU access request, held with its operands until `cpu_ready`.
- `cpu_we`  in  1  1 = write, 0 = read.
- `cpu_addr`  in  ADDR_W  access address.
- `cpu_wdata`  in  DATA_W  write data.
- `cpu_rdata`  out  DATA_W  read data, valid when `cpu_ready & cpu_req & ~cpu_we`.
- `cpu_ready`  out  1  access completes this cycle.
- `flush`  in  1  invalidate all lines.
- `mem_req`  out  1  memory request, held until `mem_ack`.
- `mem_we`  out  1  memory write.
- `mem_addr`  out  ADDR_W  memory address; equals latched `cpu_addr`.
- `mem_wdata`  out  DATA_W  memory write data.
- `mem_rdata`  in  DATA_W  memory read data, valid with `mem_ack`.
- `mem_ack`  in  1  one-cycle completion pulse.
- `hit_cnt`, `miss_cnt`  out  16  present only with `DM_CACHE_STATS_EN`.

## Operation
- Tag width: `TAG_W = ADDR_W - INDEX_W - OFFSET_W`, taken from the top address bits. Per-line storage: data, tag, valid.
- Hit condition: `valid[idx] & (tag[idx] == cpu_addr tag field)`.
- FSM states: IDLE, FILL, WRITE.
- **IDLE**
  - Read hit: `cpu_ready=1` and `cpu_rdata=data[idx]` in the same cycle. State stays IDLE.
  - Read miss: latch the address and go to FILL.
  - Any write: latch address and data. On a hit, update the line data at the next edge; the tag and valid bit are unchanged. On a miss, the line is untouched. Go to WRITE.
- **FILL**
  - `mem_req=1`, `mem_we=0`.
  - On `mem_ack`: write `mem_rdata`, the tag and `valid=1` into the line. In that same cycle, `cpu_rdata=mem_rdata` (bypass) and `cpu_ready=1`. Return to IDLE.
- **WRITE**
  - `mem_req=1`, `mem_we=1`, `mem_wdata` = latched data.
  - On `mem_ack`: `cpu_ready=1`, return to IDLE.
- **Flush**
  - Sampled only in IDLE. It clears all valid bits at the edge.
  - Flush has priority over a simultaneous `cpu_req`: `cpu_ready=0` that cycle and the request is served next cycle.
  - `flush` in FILL or WRITE is ignored. It must be held until IDLE.
- `mem_ack` while in IDLE is ignored.
- The line array has no reset. Only the valid bits reset.

## Timing
- Reset values: state IDLE, all valid = 0, `mem_req=0`, `mem_we=0`, `cpu_ready=0` (no request), counters 0. `mem_addr`, `mem_wdata` and `cpu_rdata` are don't-care until their first valid use.
- Reset during FILL or WRITE: `mem_req` drops at the next edge, no line is written, and the CPU access is abandoned.
- Latency:
  - Read hit: 0 extra cycles.
  - Read miss: N+1 cycles, where N is the cycle count from `mem_req` to `mem_ack`; minimum 2.
  - Write: same latency as a read miss.
- `mem_req` and `mem_we` are registered state decodes. They rise one cycle after the CPU request.
- `cpu_ready` is combinational from the state, hit and `mem_ack`.

## Configuration
- `DM_CACHE_STATS_EN`
  - **Defined:** `hit_cnt` increments on each IDLE read hit. `miss_cnt` increments on each entry to FILL. Both saturate at 16'hFFFF, reset to 0, and are not cleared by `flush`.
  - **Undefined:** the counters and their ports are absent. Functional behaviour is otherwise identical.

## Test plan
- Reset, then read 0x0010 with memory returning 0xBEEF after 3 cycles -> `mem_req` high for 3 cycles, `cpu_ready` plus `cpu_rdata=0xBEEF` on the ack cycle. A re-read of 0x0010 hits with 0 stall.
- After the fill above, read 0x0050 (same index 4, different tag) -> miss, refill, and a subsequent read of 0x0010 misses again.
- Write 0x1234 to 0x0010 (hit) -> `mem_we=1`, `mem_addr=0x0010`, `mem_wdata=0x1234`. The next read hits and returns 0x1234.
- Write 0xAAAA to 0x0080 (miss) -> memory is written. A following read of 0x0080 misses and fills (no allocate on write).
- Assert `flush` together with a read of a cached address -> no `cpu_ready` that cycle. Next cycle the read misses.
- Assert `rst_n=0` mid-FILL -> `mem_req` is 0 after the edge. A subsequent read of the same address misses. With `DM_CACHE_STATS_EN`, 3 hits and 2 misses read back as `hit_cnt=3`, `miss_cnt=2`.
